req_priority_encoder: RTL and testbench

- Inverse of the team's 2-to-4 active-low decoder: takes 4 active-low request lines and encodes the winning line to a 2-bit index.
- Registered, handshaked front end. Requests are synchronised, the winner is latched, and the code is held valid until the consumer acknowledges.
- Sits between asynchronous request sources (switches, peripheral strobes) and the downstream decoder/mux datapath.

---
 rtl/req_priority_encoder_pkg.sv | 38 +++
 rtl/req_priority_encoder_sync.sv | 25 ++
 rtl/req_priority_encoder.sv | 115 +++++++++++
 tb/tb_req_priority_encoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/req_priority_encoder_pkg.sv
// req_enc_pkg: shared types and helpers for req_priority_encoder.
// Optional rotating priority is enabled in the top with REQ_ROUND_ROBIN_EN.
package req_enc_pkg;

    localparam int N_REQ  = 4;
    localparam int CODE_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RELEASE
    } enc_state_t;

    // Index of the first low bit found scanning upward from start, wrapping.
    function automatic logic [CODE_W-1:0] pri_pick(
        input logic [N_REQ-1:0]  vec,
        input logic [CODE_W-1:0] start
    );
        logic [CODE_W-1:0] idx;
        logic              found;
        pri_pick = start;
        found    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = start + CODE_W'(i);
            if (!found && !vec[idx]) begin
                pri_pick = idx;
                found    = 1'b1;
            end
        end
    endfunction

    function automatic logic many_low(input logic [N_REQ-1:0] vec);
        logic [N_REQ-1:0] act;
        act = ~vec;
        many_low = (act & (act - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/req_priority_encoder_sync.sv
// req_sync: STAGES-deep multi-bit synchroniser; every flop resets to 1 (idle for active-low lines).
module req_sync #(
    parameter int STAGES = 2,
    parameter int W      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_ff [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) r_ff[i] <= '1;
        end else begin
            r_ff[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_ff[i] <= r_ff[i-1];
        end
    end

    assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/req_priority_encoder.sv
// req_priority_encoder: synchronised, handshaked 4-to-2 encoder of active-low requests.
// Define REQ_ROUND_ROBIN_EN for rotating priority; default is fixed priority, bit 0 highest.
module req_priority_encoder
    import req_enc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dis,
    input  logic [N_REQ-1:0]  req_n,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              multi,
    output logic              none
);

    enc_state_t        r_state, w_state_nx;
    logic [CODE_W-1:0] r_code, w_code_nx;
    logic [CODE_W-1:0] w_start, w_pick;
    logic              r_valid, w_valid_nx;
    logic              r_multi, w_multi_nx;
    logic              r_none;
    logic [N_REQ-1:0]  w_rq_s;

    req_sync #(
        .STAGES (SYNC_STAGES),
        .W      (N_REQ)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (req_n),
        .o_q   (w_rq_s)
    );

`ifdef REQ_ROUND_ROBIN_EN
    logic [CODE_W-1:0] r_last;

    // Reset value makes the first scan start at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_last <= CODE_W'(N_REQ - 1);
        else if (r_state == IDLE && w_state_nx == HOLD) r_last <= w_pick;
    end

    assign w_start = r_last + 1'b1;
`else
    assign w_start = '0;
`endif

    assign w_pick = pri_pick(w_rq_s, w_start);

    always_comb begin
        w_state_nx = r_state;
        w_code_nx  = r_code;
        w_valid_nx = r_valid;
        w_multi_nx = r_multi;
        if (dis) begin
            w_state_nx = IDLE;
            w_valid_nx = 1'b0;
            w_multi_nx = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rq_s != '1) begin
                        w_code_nx  = w_pick;
                        w_valid_nx = 1'b1;
                        w_multi_nx = many_low(w_rq_s);
                        w_state_nx = HOLD;
                    end
                end
                HOLD: begin
                    // ack has precedence over a simultaneous withdrawal.
                    if (ack) begin
                        w_valid_nx = 1'b0;
                        w_state_nx = RELEASE;
                    end else if (w_rq_s[r_code]) begin
                        w_valid_nx = 1'b0;
                        w_state_nx = IDLE;
                    end
                end
                RELEASE: begin
                    w_valid_nx = 1'b0;
                    w_state_nx = w_rq_s[r_code] ? IDLE : RELEASE;
                end
                default: begin
                    w_valid_nx = 1'b0;
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
            r_none  <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_code  <= w_code_nx;
            r_valid <= w_valid_nx;
            r_multi <= w_multi_nx;
            r_none  <= &w_rq_s;
        end
    end

    assign code  = r_code;
    assign valid = r_valid;
    assign multi = r_multi;
    assign none  = r_none;

endmodule

// File: tb/tb_req_priority_encoder.sv
// tb_req_priority_encoder: directed and random checks of req_priority_encoder against a behavioural model.
module tb_req_priority_encoder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       dis   = 1'b0;
    logic       ack   = 1'b0;
    logic [3:0] req_n = 4'hF;
    logic [1:0] code;
    logic       valid;
    logic       multi;
    logic       none;

    int n_vec   = 0;
    int n_err   = 0;
    int rr_last = 3;

    always #5 clk = ~clk;

    req_priority_encoder #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dis   (dis),
        .req_n (req_n),
        .ack   (ack),
        .code  (code),
        .valid (valid),
        .multi (multi),
        .none  (none)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Winner: first low line scanning upward (wrapping) from the rotating start point.
    function automatic int exp_pick(input logic [3:0] r);
        int s;
`ifdef REQ_ROUND_ROBIN_EN
        s = (rr_last + 1) % 4;
`else
        s = 0;
`endif
        for (int i = 0; i < 4; i++)
            if (r[(s + i) % 4] == 1'b0) return (s + i) % 4;
        return -1;
    endfunction

    function automatic int n_low(input logic [3:0] r);
        int c = 0;
        for (int i = 0; i < 4; i++) c += (r[i] == 1'b0) ? 1 : 0;
        return c;
    endfunction

    task automatic grant(input string tag, input logic [3:0] r, output int g);
        g = exp_pick(r);
        chk({tag, "_valid"}, 32'(valid), 1);
        chk({tag, "_code"}, 32'(code), g);
        chk({tag, "_multi"}, 32'(multi), (n_low(r) > 1) ? 1 : 0);
        chk({tag, "_none"}, 32'(none), 0);
        rr_last = g;
    endtask

    task automatic serve(input string tag);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk({tag, "_ack_drop"}, 32'(valid), 0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (valid !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        chk({tag, "_wait"}, 32'(valid), 1);
    endtask

    initial begin
        int g;
        logic [3:0] r;
        logic [3:0] r2;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("rst_code", 32'(code), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_multi", 32'(multi), 0);
        chk("rst_none", 32'(none), 1);

        // single request and exact latency
        req_n = 4'b1011;
        tick(2);
        chk("lat_early", 32'(valid), 0);
        tick(1);
        grant("single", req_n, g);
        serve("single");
        req_n = 4'hF;
        tick(3);
        chk("single_none", 32'(none), 1);
        tick(1);
        chk("single_idle", 32'(valid), 0);

        // priority and multi, then the remaining line
        req_n = 4'b0101;
        tick(3);
        grant("prio", req_n, g);
        serve("prio");
        req_n[g] = 1'b1;
        wait_valid("prio2", 10);
        grant("prio2", req_n, g);
        serve("prio2");
        req_n = 4'hF;
        tick(4);

        // abort by withdrawal without ack
        req_n = 4'b1110;
        tick(3);
        grant("abort", req_n, g);
        req_n = 4'hF;
        tick(2);
        chk("abort_hold", 32'(valid), 1);
        tick(1);
        chk("abort_drop", 32'(valid), 0);
        req_n = 4'b1011;
        tick(3);
        grant("after_abort", req_n, g);
        serve("after_abort");
        req_n = 4'hF;
        tick(4);

        // disable
        req_n = 4'b0000;
        tick(3);
        grant("dis_pre", req_n, g);
        dis = 1'b1;
        tick(1);
        chk("dis_valid", 32'(valid), 0);
        chk("dis_multi", 32'(multi), 0);
        chk("dis_code", 32'(code), g);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("dis_held", 32'(valid), 0);
        end
        dis = 1'b0;
        tick(1);
        grant("dis_post", req_n, g);

        // asynchronous reset in HOLD
        #2 rst_n = 1'b0;
        #1;
        rr_last = 3;
        chk("midrst_code", 32'(code), 0);
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_multi", 32'(multi), 0);
        chk("midrst_none", 32'(none), 1);
        req_n = 4'hF;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("postrst_valid", 32'(valid), 0);
        chk("postrst_none", 32'(none), 1);

        // all lines held; granted line blips high for one cycle after each ack
        req_n = 4'b0000;
        tick(3);
        grant("rr0", req_n, g);
        for (int i = 1; i < 5; i++) begin
            serve("rr");
            req_n[g] = 1'b1;
            tick(1);
            req_n = 4'b0000;
            tick(2);
            chk("rr_gap", 32'(valid), 0);
            tick(1);
            grant("rr", req_n, g);
        end
        serve("rr_end");
        req_n = 4'hF;
        tick(4);

        // random patterns, no-preemption while held, random ack or abort
        for (int it = 0; it < 40; it++) begin
            r = 4'($urandom_range(0, 14));
            req_n = r;
            tick(3);
            grant("rnd", r, g);
            r2 = 4'($urandom);
            r2[g] = 1'b0;
            req_n = r2;
            tick(3);
            chk("rnd_keep_valid", 32'(valid), 1);
            chk("rnd_keep_code", 32'(code), g);
            if ($urandom_range(0, 1) == 1) serve("rnd");
            req_n = 4'hF;
            tick(3);
            chk("rnd_end_valid", 32'(valid), 0);
            chk("rnd_end_none", 32'(none), 1);
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
